// File: rtl/ysyx_041461_pipe_ctrl_pkg.sv
// rtl/ysyx_041461_pipe_ctrl_pkg.sv - shared types for the pipeline controller
`include "ysyx_041461_macro.v"

package ysyx_041461_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_RUN      = `ysyx_041461_PC_RUN,
    PC_MEM_WAIT = `ysyx_041461_PC_MEM_WAIT,
    PC_FLUSH    = `ysyx_041461_PC_FLUSH
  } pc_state_e;

  typedef struct packed {
    logic mem_req;
    logic if_en;
    logic id_en;
    logic exe_en;
    logic mem_en;
    logic wb_en;
    logic id_vld;
    logic exe_vld;
    logic mem_vld;
    logic wb_vld;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{
    mem_req: 1'b0, if_en: 1'b1, id_en: 1'b1, exe_en: 1'b1, mem_en: 1'b1,
    wb_en: 1'b1, id_vld: 1'b1, exe_vld: 1'b1, mem_vld: 1'b1, wb_vld: 1'b1
  };

  // Data bus not ready: freeze IF..MEM, drain a bubble into WB.
  function automatic ctrl_t mem_stall_ctrl();
    ctrl_t c;
    c = CTRL_DEFAULT;
    c.if_en  = 1'b0;
    c.id_en  = 1'b0;
    c.exe_en = 1'b0;
    c.mem_en = 1'b0;
    c.wb_vld = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/ysyx_041461_macro.v
// rtl/ysyx_041461_macro.v - pipeline control FSM state encodings
`ifndef YSYX_041461_MACRO_V
`define YSYX_041461_MACRO_V

`define ysyx_041461_PC_RUN      2'd0
`define ysyx_041461_PC_MEM_WAIT 2'd1
`define ysyx_041461_PC_FLUSH    2'd2

`endif

// File: rtl/ysyx_041461_pipe_perf.sv
// rtl/ysyx_041461_pipe_perf.sv - stall and flush event counters
module ysyx_041461_pipe_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_evt,
  input  logic        flush_evt,
  output logic [63:0] perf_stall_cnt,
  output logic [63:0] perf_flush_cnt
);

  logic [63:0] stall_cnt_q, stall_cnt_d;
  logic [63:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {63'd0, stall_evt};
    flush_cnt_d = flush_cnt_q + {63'd0, flush_evt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 64'd0;
      flush_cnt_q <= 64'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;

endmodule

// File: rtl/ysyx_041461_pipe_ctrl.sv
// rtl/ysyx_041461_pipe_ctrl.sv - five-stage pipeline stall/flush controller
// YSYX_041461_PIPE_PERF_EN adds stall/flush performance counters.
module ysyx_041461_pipe_ctrl
  import ysyx_041461_pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ID_load_use,
  input  logic        EXE_busy,
  input  logic        EXE_redirect,
  input  logic        MEM_valid,
  input  logic        MEM_is_mem,
  input  logic        MEM_trap,
  output logic        mem_req,
  input  logic        mem_ready,
  output logic        IFreg_enable,
  output logic        IDreg_enable,
  output logic        EXEreg_enable,
  output logic        MEMreg_enable,
  output logic        WBreg_enable,
  output logic        IDreg_valid_fromCD,
  output logic        EXEreg_valid_fromCD,
  output logic        MEMreg_valid_fromCD,
  output logic        WBreg_valid_fromCD,
`ifdef YSYX_041461_PIPE_PERF_EN
  output logic [63:0] perf_stall_cnt,
  output logic [63:0] perf_flush_cnt,
`endif
  output logic [1:0]  state_out
);

  pc_state_e state_q, state_d;
  ctrl_t     ctrl;
  logic      mem_access;
  logic      mem_trap;

  assign mem_access = MEM_valid & MEM_is_mem & ~MEM_trap;
  assign mem_trap   = MEM_valid & MEM_trap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PC_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PC_RUN: begin
        if (mem_access && !mem_ready) state_d = PC_MEM_WAIT;
        else if (!mem_access && mem_trap) state_d = PC_FLUSH;
      end
      PC_MEM_WAIT: if (mem_ready) state_d = PC_RUN;
      default:     state_d = PC_RUN;
    endcase
  end

  always_comb begin
    ctrl = CTRL_DEFAULT;
    if (!rst_n) begin
      ctrl = '0;
    end else begin
      case (state_q)
        PC_RUN: begin
          if (mem_access) begin
            if (!mem_ready) ctrl = mem_stall_ctrl();
            ctrl.mem_req = 1'b1;
          end else if (mem_trap) begin
            ctrl.id_vld  = 1'b0;
            ctrl.exe_vld = 1'b0;
            ctrl.mem_vld = 1'b0;
          end else if (EXE_busy) begin
            ctrl.if_en   = 1'b0;
            ctrl.id_en   = 1'b0;
            ctrl.exe_en  = 1'b0;
            ctrl.mem_vld = 1'b0;
          end else if (EXE_redirect) begin
            ctrl.id_vld  = 1'b0;
            ctrl.exe_vld = 1'b0;
          end else if (ID_load_use) begin
            ctrl.if_en   = 1'b0;
            ctrl.id_en   = 1'b0;
            ctrl.exe_vld = 1'b0;
          end
        end
        PC_MEM_WAIT: begin
          if (!mem_ready) ctrl = mem_stall_ctrl();
          // A trap can never be paired with a bus request.
          ctrl.mem_req = ~MEM_trap;
        end
        default: begin
          ctrl.id_vld  = 1'b0;
          ctrl.exe_vld = 1'b0;
          ctrl.mem_vld = 1'b0;
        end
      endcase
    end
  end

  assign mem_req             = ctrl.mem_req;
  assign IFreg_enable        = ctrl.if_en;
  assign IDreg_enable        = ctrl.id_en;
  assign EXEreg_enable       = ctrl.exe_en;
  assign MEMreg_enable       = ctrl.mem_en;
  assign WBreg_enable        = ctrl.wb_en;
  assign IDreg_valid_fromCD  = ctrl.id_vld;
  assign EXEreg_valid_fromCD = ctrl.exe_vld;
  assign MEMreg_valid_fromCD = ctrl.mem_vld;
  assign WBreg_valid_fromCD  = ctrl.wb_vld;
  assign state_out           = state_q;

`ifdef YSYX_041461_PIPE_PERF_EN
  logic stall_evt;
  logic flush_evt;
  logic redirect_act;

  assign stall_evt    = ~ctrl.mem_en | ~ctrl.id_en;
  assign redirect_act = (state_q == PC_RUN) & ~mem_access & ~mem_trap & ~EXE_busy & EXE_redirect;
  assign flush_evt    = ((state_q != PC_FLUSH) & (state_d == PC_FLUSH)) | redirect_act;

  ysyx_041461_pipe_perf u_perf (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_evt      (stall_evt),
    .flush_evt      (flush_evt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_ysyx_041461_pipe_ctrl.sv
// tb/tb_ysyx_041461_pipe_ctrl.sv - scoreboard bench for the pipeline controller
module tb_ysyx_041461_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic ID_load_use, EXE_busy, EXE_redirect;
  logic MEM_valid, MEM_is_mem, MEM_trap, mem_ready;
  logic mem_req;
  logic IFreg_enable, IDreg_enable, EXEreg_enable, MEMreg_enable, WBreg_enable;
  logic IDreg_valid_fromCD, EXEreg_valid_fromCD, MEMreg_valid_fromCD, WBreg_valid_fromCD;
  logic [1:0] state_out;
`ifdef YSYX_041461_PIPE_PERF_EN
  logic [63:0] perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  ysyx_041461_pipe_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ID_load_use         (ID_load_use),
    .EXE_busy            (EXE_busy),
    .EXE_redirect        (EXE_redirect),
    .MEM_valid           (MEM_valid),
    .MEM_is_mem          (MEM_is_mem),
    .MEM_trap            (MEM_trap),
    .mem_req             (mem_req),
    .mem_ready           (mem_ready),
    .IFreg_enable        (IFreg_enable),
    .IDreg_enable        (IDreg_enable),
    .EXEreg_enable       (EXEreg_enable),
    .MEMreg_enable       (MEMreg_enable),
    .WBreg_enable        (WBreg_enable),
    .IDreg_valid_fromCD  (IDreg_valid_fromCD),
    .EXEreg_valid_fromCD (EXEreg_valid_fromCD),
    .MEMreg_valid_fromCD (MEMreg_valid_fromCD),
    .WBreg_valid_fromCD  (WBreg_valid_fromCD),
`ifdef YSYX_041461_PIPE_PERF_EN
    .perf_stall_cnt      (perf_stall_cnt),
    .perf_flush_cnt      (perf_flush_cnt),
`endif
    .state_out           (state_out)
  );

  // Expected control word: enables/bubbles listed IF..WB, stage bit order IF,ID,EXE,MEM,WB.
  typedef struct {
    logic        mem_req;
    logic [4:0]  en;
    logic [3:0]  vld;
    logic [1:0]  st;
    longint unsigned stall_cnt;
    longint unsigned flush_cnt;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: the pipeline is either running, waiting on the bus, or in its flush cycle.
  bit waiting_on_bus = 0;
  bit flushing       = 0;
  longint unsigned n_stall = 0;
  longint unsigned n_flush = 0;

  task automatic step(input bit rst, input bit lu, input bit busy, input bit redir,
                      input bit mv, input bit mim, input bit mt, input bit rdy, input string tag);
    exp_t e;
    bit [4:0] frozen;
    bit [3:0] bubble;
    bit wanted_bus;
    @(posedge clk);
    #1;
    rst_n = rst; ID_load_use = lu; EXE_busy = busy; EXE_redirect = redir;
    MEM_valid = mv; MEM_is_mem = mim; MEM_trap = mt; mem_ready = rdy;
    e.tag = tag;
    if (!rst) begin
      waiting_on_bus = 0; flushing = 0; n_stall = 0; n_flush = 0;
      e.mem_req = 0; e.en = 0; e.vld = 0; e.st = 0; e.stall_cnt = 0; e.flush_cnt = 0;
      exp_q.push_back(e);
      return;
    end
    frozen = 0; bubble = 0; e.mem_req = 0;
    e.st = waiting_on_bus ? 2'd1 : (flushing ? 2'd2 : 2'd0);
    e.stall_cnt = n_stall; e.flush_cnt = n_flush;
    wanted_bus = waiting_on_bus || (!flushing && mv && mim && !mt);
    if (flushing) begin
      bubble = 4'b1110;
      flushing = 0;
    end else if (wanted_bus) begin
      e.mem_req = !mt;
      waiting_on_bus = !rdy;
      if (!rdy) begin frozen = 5'b11110; bubble = 4'b0001; end
    end else if (mv && mt) begin
      bubble = 4'b1110;
      flushing = 1;
      n_flush++;
    end else if (busy) begin
      frozen = 5'b11100; bubble = 4'b0010;
    end else if (redir) begin
      bubble = 4'b1100;
      n_flush++;
    end else if (lu) begin
      frozen = 5'b11000; bubble = 4'b0100;
    end
    if (frozen[1] || frozen[3]) n_stall++;
    e.en  = ~frozen;
    e.vld = ~bubble;
    exp_q.push_back(e);
  endtask

  // Monitor: samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [4:0] got_en;
      logic [3:0] got_vld;
      e = exp_q.pop_front();
      got_en  = {IFreg_enable, IDreg_enable, EXEreg_enable, MEMreg_enable, WBreg_enable};
      got_vld = {IDreg_valid_fromCD, EXEreg_valid_fromCD, MEMreg_valid_fromCD, WBreg_valid_fromCD};
      checks++;
      if ({mem_req, got_en, got_vld, state_out} !== {e.mem_req, e.en, e.vld, e.st}) begin
        errors++;
        $display("FAIL %s t=%0t: got req=%b en=%b vld=%b st=%0d, want req=%b en=%b vld=%b st=%0d",
                 e.tag, $time, mem_req, got_en, got_vld, state_out, e.mem_req, e.en, e.vld, e.st);
      end
`ifdef YSYX_041461_PIPE_PERF_EN
      checks++;
      if (perf_stall_cnt !== e.stall_cnt || perf_flush_cnt !== e.flush_cnt) begin
        errors++;
        $display("FAIL %s_perf t=%0t: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
                 e.tag, $time, perf_stall_cnt, perf_flush_cnt, e.stall_cnt, e.flush_cnt);
      end
`endif
    end
  end

  initial begin
    rst_n = 0; ID_load_use = 0; EXE_busy = 0; EXE_redirect = 0;
    MEM_valid = 0; MEM_is_mem = 0; MEM_trap = 0; mem_ready = 0;
    //    rst lu bs rd mv mi mt rdy
    step(0, 0, 0, 0, 0, 0, 0, 0, "reset");
    step(0, 1, 1, 1, 1, 1, 0, 0, "reset_inputs_active");
    step(1, 0, 0, 0, 0, 0, 0, 0, "post_reset_default");
    // Load with three not-ready cycles then ready.
    step(1, 0, 0, 0, 1, 1, 0, 0, "load_wait0");
    step(1, 1, 1, 1, 1, 1, 0, 0, "load_wait1");
    step(1, 0, 0, 0, 1, 1, 0, 0, "load_wait2");
    step(1, 0, 0, 0, 1, 1, 0, 1, "load_done");
    step(1, 0, 0, 0, 1, 1, 0, 1, "load_hit");
    step(1, 0, 0, 0, 0, 0, 0, 0, "idle");
    // Trap on a memory op, then flush cycle with lower events ignored.
    step(1, 0, 0, 0, 1, 1, 1, 1, "trap");
    step(1, 1, 1, 1, 0, 0, 0, 0, "flush");
    step(1, 0, 0, 0, 0, 0, 0, 0, "after_flush");
    // Busy with redirect pending for five cycles, then busy drops.
    for (int i = 0; i < 5; i++) step(1, 0, 1, 1, 0, 0, 0, 0, "busy_redir");
    step(1, 0, 0, 1, 0, 0, 0, 0, "redir_after_busy");
    step(1, 1, 0, 1, 0, 0, 0, 0, "redir_over_loaduse");
    step(1, 1, 0, 0, 0, 0, 0, 0, "loaduse");
    // Reset in the second bus-wait cycle.
    step(1, 0, 0, 0, 1, 1, 0, 0, "wait_a");
    step(1, 0, 0, 0, 1, 1, 0, 0, "wait_b");
    step(0, 0, 0, 0, 1, 1, 0, 0, "reset_in_wait");
    step(1, 0, 0, 0, 0, 0, 0, 1, "release_default");
    step(1, 0, 0, 0, 0, 0, 0, 0, "release_idle");
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, mv, mim, mt;
      r   = ($urandom_range(0, 199) != 0);
      mv  = ($urandom_range(0, 2) != 0);
      mim = ($urandom_range(0, 2) == 0);
      mt  = ($urandom_range(0, 9) == 0);
      step(r, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
           mv, mim, mt, $urandom_range(0, 1) == 1, "random");
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
